// File: rtl/alu_shift_seq_pkg.sv
// Shared definitions for the accumulator shifter/rotator.
// Contents: default parameters, shift-mode encodings, FSM state encodings,
// and a helper that flags reserved mode codes.
package alu_shift_seq_pkg;

    localparam int DEF_WIDTH = 56;
    localparam int DEF_CNT_W = 6;
    localparam int DEF_STEP  = 1;

    // Codes 5..7 are reserved and act as a passthrough.
    typedef enum logic [2:0] {
        MODE_ASL = 3'd0,
        MODE_ASR = 3'd1,
        MODE_LSR = 3'd2,
        MODE_ROL = 3'd3,
        MODE_ROR = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic is_reserved(input logic [2:0] m);
        return m > 3'd4;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational k-bit shift/rotate step, built as k chained 1-bit steps so a
// multi-bit step is by construction identical to k single-bit steps.
// Ports:
//   value  - operand before the step
//   mode   - shift mode (reserved codes leave the value untouched)
//   k      - number of bit positions this step, 1..STEP
//   result - operand after the step
//   carry  - bit shifted or wrapped out by the last 1-bit step
//   ovf    - ASL only: sign bit changed in at least one 1-bit step
module alu_shift_step
    import alu_shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP,
    parameter int K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  mode_t            mode,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    always_comb begin
        result = value;
        carry  = 1'b0;
        ovf    = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                case (mode)
                    MODE_ASL: begin
                        carry = result[WIDTH-1];
                        // The new sign is the current bit WIDTH-2.
                        if (result[WIDTH-1] != result[WIDTH-2]) ovf = 1'b1;
                        result = {result[WIDTH-2:0], 1'b0};
                    end
                    MODE_ASR: begin
                        carry  = result[0];
                        result = {result[WIDTH-1], result[WIDTH-1:1]};
                    end
                    MODE_LSR: begin
                        carry  = result[0];
                        result = {1'b0, result[WIDTH-1:1]};
                    end
                    MODE_ROL: begin
                        carry  = result[WIDTH-1];
                        result = {result[WIDTH-2:0], result[WIDTH-1]};
                    end
                    MODE_ROR: begin
                        carry  = result[0];
                        result = {result[0], result[WIDTH-1:1]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shifter/rotator on the accumulator path.
// Handshake: start is sampled only in IDLE; the accepting edge latches din,
// mode and count, after which those inputs are don't-care. busy is high in
// SHIFT and DONE; done is a one-cycle pulse while the result is valid.
// dout/carry/ovf hold until the next accepted start.
// Ports:
//   clk, reset_n      - rising-edge clock, asynchronous active-low reset
//   start, mode, count, din - launch request and operands
//   busy, done        - handshake status
//   dout, carry, ovf  - result, last bit out, sticky ASL overflow
//   state             - current FSM state (debug visibility)
module alu_shift_seq
    import alu_shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             ovf,
    output state_t           state
);

    localparam int K_W = $clog2(STEP + 1);

    mode_t            op;
    logic [CNT_W-1:0] rem;
    logic [K_W-1:0]   k;
    logic [WIDTH-1:0] step_result;
    logic             step_carry;
    logic             step_ovf;

    // Bits to move this cycle: min(STEP, remaining).
    always_comb begin
        if (rem < CNT_W'(STEP)) k = K_W'(rem);
        else                    k = K_W'(STEP);
    end

    alu_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .value  (dout),
        .mode   (op),
        .k      (k),
        .result (step_result),
        .carry  (step_carry),
        .ovf    (step_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            op    <= MODE_ASL;
            rem   <= '0;
            dout  <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dout  <= din;
                        op    <= mode_t'(mode);
                        rem   <= count;
                        carry <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        // Nothing to shift: skip straight to the result.
                        if (count == '0 || is_reserved(mode)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    dout  <= step_result;
                    carry <= step_carry;
                    ovf   <= ovf | step_ovf;
                    rem   <= rem - CNT_W'(k);
                    if (rem <= CNT_W'(STEP)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq: one STEP=1 and one STEP=4 instance.
module tb_alu_shift_seq;
    import alu_shift_seq_pkg::*;

    localparam int W = 56;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic          start1 = 1'b0, start4 = 1'b0;
    logic [2:0]    mode1 = '0, mode4 = '0;
    logic [CW-1:0] count1 = '0, count4 = '0;
    logic [W-1:0]  din1 = '0, din4 = '0;
    logic          busy1, busy4, done1, done4, carry1, carry4, ovf1, ovf4;
    logic [W-1:0]  dout1, dout4;
    state_t        state1, state4;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    alu_shift_seq #(.WIDTH(W), .CNT_W(CW), .STEP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode1), .count(count1),
        .din(din1), .busy(busy1), .done(done1), .dout(dout1), .carry(carry1),
        .ovf(ovf1), .state(state1)
    );

    alu_shift_seq #(.WIDTH(W), .CNT_W(CW), .STEP(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .mode(mode4), .count(count4),
        .din(din4), .busy(busy4), .done(done4), .dout(dout4), .carry(carry4),
        .ovf(ovf4), .state(state4)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver ----------------
    // Launches one operation and samples at negedges. lat is the number of
    // edges after the accepting edge at which done was registered high.
    task automatic run_op(input bit s4, input logic [2:0] m, input logic [CW-1:0] c,
                          input logic [W-1:0] d, input bit poke,
                          output int lat, output int shifts, output logic [W-1:0] r,
                          output logic cy, output logic ov, output bit busy_ok);
        logic b, dn;
        state_t st;
        @(negedge clk);
        if (s4) begin start4 = 1'b1; mode4 = m; count4 = c; din4 = d; end
        else    begin start1 = 1'b1; mode1 = m; count1 = c; din1 = d; end
        lat = -1; shifts = 0; busy_ok = 1'b1; r = '0; cy = 1'b0; ov = 1'b0;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(negedge clk);
            if (i == 1 && poke) begin
                // A second request while busy must be ignored.
                if (s4) begin start4 = 1'b1; mode4 = 3'd4; count4 = 6'd5; din4 = '1; end
                else    begin start1 = 1'b1; mode1 = 3'd4; count1 = 6'd5; din1 = '1; end
            end else begin
                // Operands are don't-care after acceptance; scramble them.
                if (s4) begin start4 = 1'b0; din4 = ~d; mode4 = 3'd2; count4 = ~c; end
                else    begin start1 = 1'b0; din1 = ~d; mode1 = 3'd2; count1 = ~c; end
            end
            b  = s4 ? busy4 : busy1;
            dn = s4 ? done4 : done1;
            st = s4 ? state4 : state1;
            if (st == S_SHIFT) shifts++;
            if (!b) busy_ok = 1'b0;
            if (dn) begin
                lat = i;
                r   = s4 ? dout4 : dout1;
                cy  = s4 ? carry4 : carry1;
                ov  = s4 ? ovf4 : ovf1;
            end
        end
        if (s4) start4 = 1'b0; else start1 = 1'b0;
        if (lat < 0) check("done_timeout", 64'(0), 64'(1));
        @(negedge clk);
        check("done_pulse_end", 64'(s4 ? done4 : done1), 64'(0));
        check("busy_end", 64'(s4 ? busy4 : busy1), 64'(0));
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        int lat, shifts;
        logic [W-1:0] r, r_ref;
        logic cy, ov;
        bit bok;

        #3;
        check("rst_dout", 64'(dout1), 64'(0));
        check("rst_flags", 64'({busy1, done1, carry1, ovf1}), 64'(0));
        check("rst_state", 64'(state1), 64'(S_IDLE));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // ASL 3 of 1
        run_op(0, 3'd0, 6'd3, 56'h00000000000001, 0, lat, shifts, r, cy, ov, bok);
        check("asl3_dout", 64'(r), 64'h00000000000008);
        check("asl3_flags", 64'({cy, ov}), 64'(0));
        check("asl3_lat", 64'(lat), 64'(3));
        check("asl3_busy", 64'(bok), 64'(1));
        check("asl3_shifts", 64'(shifts), 64'(3));

        // ASR 4 then LSR 4 of the sign bit
        run_op(0, 3'd1, 6'd4, 56'h80000000000000, 0, lat, shifts, r, cy, ov, bok);
        check("asr4_dout", 64'(r), 64'h00F8000000000000);
        check("asr4_carry", 64'(cy), 64'(0));
        run_op(0, 3'd2, 6'd4, 56'h80000000000000, 0, lat, shifts, r, cy, ov, bok);
        check("lsr4_dout", 64'(r), 64'h0008000000000000);

        // ASL overflow
        run_op(0, 3'd0, 6'd1, 56'h40000000000000, 0, lat, shifts, r, cy, ov, bok);
        check("aslovf_dout", 64'(r), 64'h0080000000000000);
        check("aslovf_ovf", 64'(ov), 64'(1));
        check("aslovf_carry", 64'(cy), 64'(0));
        check("ovf_hold", 64'(ovf1), 64'(1));

        // Reserved mode directly after an overflow: flags cleared, passthrough
        run_op(0, 3'd6, 6'd9, 56'hABCDEF01234567, 0, lat, shifts, r, cy, ov, bok);
        check("rsv_dout", 64'(r), 64'h00ABCDEF01234567);
        check("rsv_flags", 64'({cy, ov}), 64'(0));
        check("rsv_lat", 64'(lat), 64'(0));

        // ROR 1 of 1
        run_op(0, 3'd4, 6'd1, 56'h00000000000001, 0, lat, shifts, r, cy, ov, bok);
        check("ror1_dout", 64'(r), 64'h0080000000000000);
        check("ror1_carry", 64'(cy), 64'(1));

        // count=0 after a carry=1 result
        run_op(0, 3'd0, 6'd0, 56'h123456789ABCDE, 0, lat, shifts, r, cy, ov, bok);
        check("cnt0_dout", 64'(r), 64'h00123456789ABCDE);
        check("cnt0_carry", 64'(cy), 64'(0));
        check("cnt0_lat", 64'(lat), 64'(0));
        check("cnt0_shifts", 64'(shifts), 64'(0));

        // ROL 57 equals ROL 1
        run_op(0, 3'd3, 6'd1, 56'h80000000000001, 0, lat, shifts, r_ref, cy, ov, bok);
        check("rol1_dout", 64'(r_ref), 64'h00000000000003);
        check("rol1_carry", 64'(cy), 64'(1));
        run_op(0, 3'd3, 6'd57, 56'h80000000000001, 0, lat, shifts, r, cy, ov, bok);
        check("rol57_dout", 64'(r), 64'h00000000000003);
        check("rol57_carry", 64'(cy), 64'(1));
        check("rol57_lat", 64'(lat), 64'(57));

        // start while busy is ignored
        run_op(0, 3'd0, 6'd3, 56'h00000000000001, 1, lat, shifts, r, cy, ov, bok);
        check("poke_dout", 64'(r), 64'h00000000000008);
        check("poke_lat", 64'(lat), 64'(3));
        repeat (2) @(negedge clk);
        check("poke_hold", 64'(dout1), 64'h00000000000008);
        check("poke_idle", 64'(busy1), 64'(0));

        // STEP=4 instance
        run_op(1, 3'd0, 6'd6, 56'h00000000000003, 0, lat, shifts, r, cy, ov, bok);
        check("s4_asl6_dout", 64'(r), 64'h000000000000C0);
        check("s4_asl6_shifts", 64'(shifts), 64'(2));
        check("s4_asl6_lat", 64'(lat), 64'(2));
        check("s4_asl6_flags", 64'({cy, ov}), 64'(0));
        run_op(1, 3'd0, 6'd2, 56'h20000000000000, 0, lat, shifts, r, cy, ov, bok);
        check("s4_asl2_dout", 64'(r), 64'h0080000000000000);
        check("s4_asl2_ovf", 64'(ov), 64'(1));
        check("s4_asl2_carry", 64'(cy), 64'(0));
        run_op(1, 3'd1, 6'd63, 56'h80000000000000, 0, lat, shifts, r, cy, ov, bok);
        check("s4_asr63_dout", 64'(r), 64'h00FFFFFFFFFFFFFF);
        check("s4_asr63_carry", 64'(cy), 64'(1));
        check("s4_asr63_lat", 64'(lat), 64'(16));
        run_op(1, 3'd2, 6'd60, 56'hFFFFFFFFFFFFFF, 0, lat, shifts, r, cy, ov, bok);
        check("s4_lsr60_dout", 64'(r), 64'(0));
        check("s4_lsr60_carry", 64'(cy), 64'(0));

        // Reset mid-SHIFT
        @(negedge clk);
        start1 = 1'b1; mode1 = 3'd0; count1 = 6'd50; din1 = 56'h40000000000001;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_dout", 64'(dout1), 64'h00000000000004);
        check("mid_flags", 64'({carry1, ovf1, busy1}), 64'b111);
        #2 reset_n = 1'b0;
        #1;
        check("arst_dout", 64'(dout1), 64'(0));
        check("arst_flags", 64'({busy1, done1, carry1, ovf1}), 64'(0));
        check("arst_state", 64'(state1), 64'(S_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        run_op(0, 3'd0, 6'd3, 56'h00000000000001, 0, lat, shifts, r, cy, ov, bok);
        check("post_rst_dout", 64'(r), 64'h00000000000008);
        check("post_rst_lat", 64'(lat), 64'(3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
